// File: rtl/qnigma_add_mw.sv
// Limb-serial multi-word adder/subtractor: one L-bit limb per clock with a registered
// carry/borrow, valid/ready on both sides. Subtraction runs as A + ~B + ~cin.
module qnigma_add_mw #(
    parameter int unsigned W = 256,
    parameter int unsigned L = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_val,
    output logic         in_rdy,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_val,
    input  logic         out_rdy,
    output logic [W-1:0] q,
    output logic         cout
);

    localparam int unsigned N  = W / L;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LW = L + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   q_q;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic           sub_q;
    logic           in_rdy_q;
    logic           out_val_q;
    logic           cout_q;

    logic [LW-1:0]  sum_d;
    logic           last_d;

    // Operand registers shift right each RUN cycle, so the active limb is always at the bottom.
    assign sum_d  = LW'(a_q[L-1:0]) + LW'(b_q[L-1:0]) + LW'(carry_q);
    assign last_d = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            in_rdy_q  <= 1'b0;
            out_val_q <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_val && in_rdy_q) begin
                        a_q      <= a;
                        b_q      <= sub ? ~b : b;
                        sub_q    <= sub;
                        carry_q  <= cin ^ sub;
                        cnt_q    <= '0;
                        in_rdy_q <= 1'b0;
                        state_q  <= RUN;
                    end else begin
                        in_rdy_q <= 1'b1;
                    end
                end
                RUN: begin
                    q_q[cnt_q*L +: L] <= sum_d[L-1:0];
                    carry_q           <= sum_d[L];
                    a_q               <= a_q >> L;
                    b_q               <= b_q >> L;
                    cnt_q             <= cnt_q + CW'(1);
                    if (last_d) begin
                        // Final carry is inverted when subtracting to give the borrow.
                        cout_q    <= sum_d[L] ^ sub_q;
                        out_val_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        out_val_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_val = out_val_q;
    assign q       = q_q;
    assign cout    = cout_q;

endmodule

// File: doc/qnigma_add_mw.md
Name: qnigma_add_mw

Overview:
Multi-word, limb-serial adder/subtractor for wide operands such as field elements and big integers in the qnigma math datapath. It processes one L-bit limb per clock and keeps a registered carry/borrow between limbs. Operands and result move over valid/ready handshakes, so the block sits directly between sequencing logic and the modular-reduction stage. Trades latency for area compared with a single-cycle W-bit adder.

Parameters:
W, 256, operand/result width in bits; must be a multiple of L
L, 32, limb width in bits processed per cycle; 1 <= L <= W
N, W/L (derived, localparam), number of limbs = cycles per operation

Ports:
clk      input   1  clock, rising edge
rst_n    input   1  asynchronous reset, active low
in_val   input   1  operand valid
in_rdy   output  1  block ready to accept operands
a        input   W  operand A
b        input   W  operand B
cin      input   1  carry-in (add) / borrow-in (sub)
sub      input   1  0: add, 1: subtract
out_val  output  1  result valid
out_rdy  input   1  downstream ready
q        output  W  result, modulo 2^W
cout     output  1  carry-out (add) / borrow-out (sub)

Behaviour:
- Reset (rst_n=0, async): state IDLE; in_rdy=0 while rst_n=0, 1 from the first clk after release; out_val=0; q=0; cout=0; limb counter=0; carry register=0. Reset during RUN or DONE aborts the operation with no output.
- Arithmetic: sub=0 -> {cout,q} = a + b + cin. sub=1 -> q = (a - b - cin) mod 2^W; cout=1 iff a < b + cin (unsigned borrow).
  - Implementation: A + ~B + ~cin per limb, with cout = inverted final carry.
- States:
  - IDLE: in_rdy=1. On in_val&in_rdy, latch a, b (bitwise-inverted if sub), sub, and initial carry (cin, or ~cin if sub). Counter=0 -> RUN.
  - RUN: in_rdy=0. Each cycle compute limb k = A[k] + B[k] + carry (L+1 bits). Store the low L bits into result limb k; carry <= bit L; k++. After limb N-1 -> DONE.
  - DONE: out_val=1; q and cout stable and held until out_val&out_rdy. On handshake -> IDLE, out_val=0 next cycle.
- Latency: accept on edge t; out_val first high after edge t+N. Throughput is one operation per N+2 cycles minimum, with no overlap (in_rdy=0 in RUN and DONE).
- Inputs a, b, cin, sub are sampled only at accept; changes afterwards are ignored.
- in_val while in_rdy=0 is ignored; the source must hold it (standard valid/ready, no drop).
- out_rdy held high in DONE: result consumed in one cycle. out_rdy low: hold indefinitely.
- q updates only at limb writes; q from the previous operation is not guaranteed once RUN starts (out_val=0).
- N=1 (L=W): single RUN cycle, same protocol.
- Limb order: least significant first; q[L*k +: L] holds limb k.

Test Plan:
- W=64, L=16, add: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> q=0, cout=1; out_val rises exactly 4 cycles after accept, carry ripples across all 4 limbs.
- Subtract: a=0, b=1, cin=0, sub=1 -> q=FFFF_FFFF_FFFF_FFFF, cout=1. Then a=5, b=3, cin=1, sub=1 -> q=1, cout=0.
- Back-pressure: hold out_rdy=0 for 10 cycles in DONE -> q, cout, out_val stable, in_rdy=0, new in_val ignored. Release -> handshake, in_rdy=1 next cycle.
- Reset mid-RUN: deassert rst_n after limb 1 -> out_val=0, q=0, cout=0 immediately (async). After release, a fresh add of 0x1234+0x1 gives q=0x1235, cout=0.
- Random regression: 10k random a, b, cin, sub with random in_val/out_rdy gaps, W=256/L=32 and W=L=64 (N=1) -> all results match a reference model; no lost or duplicated transactions.
